// File: rtl/fp_divsqrt_allocator_if.sv
// Issue-side / lane-side bundle for the FP div/sqrt lane allocator.
// master: issue/select + lane controllers (drive requests, releases, flushes)
// slave : the allocator (drives grants, acquire strobes, ownership status)
interface fp_divsqrt_allocator_if #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned NUM_UNIT = 2,
  parameter int unsigned AL_W     = 6
);
  localparam int unsigned UW   = (NUM_UNIT > 1) ? $clog2(NUM_UNIT) : 1;
  localparam int unsigned FC_W = $clog2(NUM_UNIT + 1);

  logic [NUM_REQ-1:0]                 acqReq;
  logic [NUM_REQ-1:0][AL_W-1:0]       acqPtr;
  logic [NUM_REQ-1:0]                 acqGrant;
  logic [NUM_REQ-1:0][UW-1:0]         acqUnit;
  logic [NUM_UNIT-1:0]                unitAcquire;
  logic [NUM_UNIT-1:0][AL_W-1:0]      unitAcquirePtr;
  logic [NUM_UNIT-1:0]                relValid;
  logic                               flushValid;
  logic                               flushAll;
  logic [AL_W-1:0]                    flushHead;
  logic [AL_W-1:0]                    flushTail;
  logic [NUM_UNIT-1:0]                unitOwned;
  logic [FC_W-1:0]                    freeCount;

  modport master (
    output acqReq, acqPtr, relValid, flushValid, flushAll, flushHead, flushTail,
    input  acqGrant, acqUnit, unitAcquire, unitAcquirePtr, unitOwned, freeCount
  );

  modport slave (
    input  acqReq, acqPtr, relValid, flushValid, flushAll, flushHead, flushTail,
    output acqGrant, acqUnit, unitAcquire, unitAcquirePtr, unitOwned, freeCount
  );
endinterface

// File: rtl/fp_divsqrt_allocator.sv
// FP div/sqrt lane allocator.
// Grants free lanes to issue-side requesters in round-robin order (same-cycle
// grant), tracks per-lane ownership and owner pointer, and frees lanes on
// release or when the owner is squashed by a selective/full flush.
// Ports: clk, rst (sync, active-high), bus (slave side of the bundle):
//   acqReq/acqPtr in, acqGrant/acqUnit out (comb), unitAcquire/unitAcquirePtr
//   out (comb), relValid/flush* in, unitOwned/freeCount out (registered).
module fp_divsqrt_allocator #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned NUM_UNIT = 2,
  parameter int unsigned AL_W     = 6
) (
  input logic                   clk,
  input logic                   rst,
  fp_divsqrt_allocator_if.slave bus
);
  localparam int unsigned UW   = (NUM_UNIT > 1) ? $clog2(NUM_UNIT) : 1;
  localparam int unsigned UW_R = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned FC_W = $clog2(NUM_UNIT + 1);

  typedef enum logic {LANE_FREE, LANE_OWNED} lane_state_e;

  lane_state_e                   lane_state [NUM_UNIT];
  logic [NUM_UNIT-1:0][AL_W-1:0] owner_ptr;
  logic [UW_R-1:0]               rr_ptr;
  logic [FC_W-1:0]               free_cnt;

  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0][UW-1:0]    unit_sel;
  logic [NUM_UNIT-1:0]           acq;
  logic [NUM_UNIT-1:0][AL_W-1:0] acq_ptr;
  logic [NUM_UNIT-1:0]           given;
  logic                          any_grant;
  logic [UW_R-1:0]               last_r;
  logic [UW_R-1:0]               r_idx;
  logic [UW_R-1:0]               rr_next;
  logic                          found;
  int unsigned                   r_sum;

  logic [NUM_UNIT-1:0]           owned_q;
  logic [NUM_UNIT-1:0]           drop;
  logic [NUM_UNIT-1:0]           owned_next;
  logic [AL_W-1:0]               owner_off;
  logic [AL_W-1:0]               range_len;
  logic [FC_W-1:0]               owned_cnt;
  logic [FC_W-1:0]               free_next;

  always_comb begin
    for (int u = 0; u < int'(NUM_UNIT); u++) begin
      owned_q[u] = (lane_state[u] == LANE_OWNED);
    end
  end

  // Round-robin arbitration: walk requesters from rr_ptr, each takes the
  // lowest free lane not already handed out this cycle.
  always_comb begin
    grant     = '0;
    unit_sel  = '0;
    acq       = '0;
    acq_ptr   = '0;
    given     = '0;
    any_grant = 1'b0;
    last_r    = '0;
    r_idx     = '0;
    found     = 1'b0;
    r_sum     = 0;
    if (!rst && !bus.flushValid) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        r_sum = 32'(rr_ptr) + i;
        if (r_sum >= NUM_REQ) r_sum = r_sum - NUM_REQ;
        r_idx = UW_R'(r_sum);
        found = 1'b0;
        for (int u = 0; u < int'(NUM_UNIT); u++) begin
          if (bus.acqReq[r_idx] && !found && !owned_q[u] && !given[u]) begin
            found           = 1'b1;
            given[u]        = 1'b1;
            acq[u]          = 1'b1;
            acq_ptr[u]      = bus.acqPtr[r_idx];
            grant[r_idx]    = 1'b1;
            unit_sel[r_idx] = UW'(u);
            any_grant       = 1'b1;
            last_r          = r_idx;
          end
        end
      end
    end
  end

  always_comb begin
    rr_next = rr_ptr;
    if (any_grant) begin
      rr_next = (last_r == UW_R'(NUM_REQ - 1)) ? '0 : last_r + UW_R'(1);
    end
  end

  // Drop ownership on release or flush; the modular offset test handles
  // ranges that wrap past the top of the active list.
  always_comb begin
    drop       = '0;
    owned_next = '0;
    owner_off  = '0;
    owned_cnt  = '0;
    range_len  = bus.flushTail - bus.flushHead;
    for (int u = 0; u < int'(NUM_UNIT); u++) begin
      owner_off = owner_ptr[u] - bus.flushHead;
      drop[u]   = owned_q[u] &&
                  (bus.relValid[u] ||
                   (bus.flushValid && (bus.flushAll || (owner_off < range_len))));
      owned_next[u] = (owned_q[u] && !drop[u]) || acq[u];
      owned_cnt     = owned_cnt + FC_W'(owned_next[u]);
    end
    free_next = FC_W'(NUM_UNIT) - owned_cnt;
  end

  // Lane state, owner pointers, round-robin pointer and free count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int u = 0; u < int'(NUM_UNIT); u++) begin
        lane_state[u] <= LANE_FREE;
      end
      owner_ptr <= '0;
      rr_ptr    <= '0;
      free_cnt  <= FC_W'(NUM_UNIT);
    end else begin
      for (int u = 0; u < int'(NUM_UNIT); u++) begin
        lane_state[u] <= owned_next[u] ? LANE_OWNED : LANE_FREE;
        if (acq[u]) owner_ptr[u] <= acq_ptr[u];
      end
      rr_ptr   <= rr_next;
      free_cnt <= free_next;
    end
  end

  assign bus.acqGrant       = grant;
  assign bus.acqUnit        = unit_sel;
  assign bus.unitAcquire    = acq;
  assign bus.unitAcquirePtr = acq_ptr;
  assign bus.unitOwned      = owned_q;
  assign bus.freeCount      = free_cnt;

endmodule

// File: doc/fp_divsqrt_allocator.md
# fp_divsqrt_allocator

Allocates the pool of FP div/sqrt lanes among the issue-stage requesters. Each cycle it grants free lanes to acquiring instructions in round-robin requester order, drives each lane's acquire strobe and active-list pointer, tracks lane ownership until release, and frees lanes whose owner is squashed by a selective or full flush. It sits between the FP issue/select logic and the per-lane div/sqrt phase controllers.

## Interface
- NUM_REQ, 2, number of issue-side requesters (≥1)
- NUM_UNIT, 2, number of div/sqrt lanes (≥1)
- AL_W, 6, active-list index width; UW = max(1, clog2(NUM_UNIT))
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- acqReq  in  NUM_REQ  requester r wants a lane this cycle
- acqPtr  in  NUM_REQ×AL_W  active-list pointer of requester r
- acqGrant  out  NUM_REQ  requester r granted (combinational, same cycle)
- acqUnit  out  NUM_REQ×UW  lane granted to r (0 when not granted)
- unitAcquire  out  NUM_UNIT  acquire strobe to lane u
- unitAcquirePtr  out  NUM_UNIT×AL_W  pointer sent with the strobe (0 when idle)
- relValid  in  NUM_UNIT  lane u's owner has taken its result
- flushValid  in  1  recovery flush this cycle
- flushAll  in  1  flush every owner (qualified by flushValid)
- flushHead, flushTail  in  AL_W each  selective flush range [head, tail)
- unitOwned  out  NUM_UNIT  registered ownership per lane
- freeCount  out  clog2(NUM_UNIT+1)  registered count of unowned lanes

## Operation
- Per-lane state: FREE or OWNED, plus registered ownerPtr. One rrPtr (requester index, UW_R = max(1, clog2(NUM_REQ)) bits).
- Arbitration (combinational): with flushValid=0, visit requesters starting at rrPtr, wrapping modulo NUM_REQ. Each asserting requester gets the lowest-index lane still FREE and not yet given this cycle. Stop when no free lane remains. Ungranted requesters retry; the allocator holds no request.
- With flushValid=1 there are no grants that cycle: acqGrant=0 and unitAcquire=0.
- Grant to lane u: unitAcquire[u]=1 and unitAcquirePtr[u]=acqPtr[r]. Next cycle the lane is OWNED with ownerPtr=acqPtr[r].
- rrPtr update:
  - At least one grant: rrPtr becomes the index after the last granted requester, modulo NUM_REQ.
  - No grant: rrPtr holds.
- Release: relValid[u] on an OWNED lane sets it FREE next cycle. relValid on a FREE lane is ignored.
- Flush: an OWNED lane becomes FREE next cycle if either:
  - flushAll is set, or
  - its pointer is in the range, i.e. (ownerPtr − flushHead) mod 2^AL_W < (flushTail − flushHead) mod 2^AL_W.
- head==tail with flushAll=0 flushes nothing.
- Release and flush of the same lane in one cycle: the lane becomes FREE, counted once.
- A lane freed in cycle N is first grantable in cycle N+1. There is no same-cycle reuse.

## Timing
- Reset values: all lanes FREE, ownerPtr=0, rrPtr=0, unitOwned=0, freeCount=NUM_UNIT. Registers reset only on a rising edge with rst=1.
- While rst=1, the combinational outputs follow the reset state. Any request present during reset is lost; any lane ownership at reset is dropped.
- acqGrant, acqUnit, unitAcquire and unitAcquirePtr are combinational from the inputs and registered state. They have zero latency: issue consumes the grant in the same cycle.
- unitOwned and freeCount reflect the lane state after the previous edge.
- Invariants:
  - freeCount equals NUM_UNIT minus popcount(unitOwned) at all times.
  - No lane is granted twice in one cycle.
  - Σ acqGrant ≤ freeCount.

## Test plan
- Reset, then acqReq=2'b11 with acqPtr={5,9} and NUM_UNIT=2:
  - Same cycle: grants 2'b11, requester 0→lane 0, requester 1→lane 1, unitAcquirePtr={9,5} for lanes {1,0}.
  - Next cycle: unitOwned=2'b11, freeCount=0, rrPtr=0.
- Both lanes owned, acqReq=2'b01: acqGrant=0 and unitAcquire=0. Then relValid[1]=1: the cycle after, requester 0 gets lane 1, not in the release cycle.
- Fairness with one free lane and both requesters asserting every cycle, releasing each cycle:
  - Grants alternate r0, r1, r0, …
  - rrPtr goes 0→1→0.
- Selective flush with wrap:
  - Setup: AL_W=6, owners ptr 62 (lane 0) and ptr 3 (lane 1).
  - Flush head=60, tail=2: lane 0 freed, lane 1 kept, freeCount goes 0→1.
  - Flush head=4, tail=4: no change.
- flushAll with both lanes owned while acqReq=2'b11 is asserted:
  - That cycle: acqGrant=0.
  - Next cycle: both lanes FREE, freeCount=2. Requests are then granted.
- Simultaneous relValid[0] and an in-range flush of lane 0: lane 0 FREE once, freeCount increments by exactly 1. Also assert rst mid-operation with both lanes owned: all state returns to reset values.
